vga_plot_arbiter: RTL and testbench

//  Shares the single pixel-write port of vga_adapter between two requesters: the

---
 rtl/vga_plot_arbiter.sv | 88 ++++++++
 tb/tb_vga_plot_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin, burst-bounded sharing of the vga_adapter pixel port between BG and AIM.
module vga_plot_arbiter #(
  parameter int BURST_MAX = 16,
  parameter int X_MAX     = 320,
  parameter int Y_MAX     = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       aim_en,
  input  logic       bg_req,
  input  logic [8:0] bg_x,
  input  logic [7:0] bg_y,
  input  logic [2:0] bg_colour,
  output logic       bg_gnt,
  input  logic       aim_req,
  input  logic [8:0] aim_x,
  input  logic [7:0] aim_y,
  input  logic [2:0] aim_colour,
  output logic       aim_gnt,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] drop_cnt
);
  localparam int BW = BURST_MAX > 1 ? $clog2(BURST_MAX) : 1;
  typedef enum logic [1:0] {IDLE, SERVE_BG, SERVE_AIM} state_t;
  state_t state, state_n;
  logic last_aim, last_aim_n;
  logic [BW-1:0] burst, burst_n;
  logic aim_req_e, xfer, at_limit, in_range;
  logic [8:0] px_x;
  logic [7:0] px_y;
  logic [2:0] px_c;
  assign bg_gnt    = state == SERVE_BG;
  assign aim_gnt   = state == SERVE_AIM;
  assign aim_req_e = aim_req & aim_en;
  assign xfer      = (bg_gnt & bg_req) | (aim_gnt & aim_req_e);
  assign at_limit  = burst == BW'(BURST_MAX - 1);
  assign px_x      = bg_gnt ? bg_x : aim_x;
  assign px_y      = bg_gnt ? bg_y : aim_y;
  assign px_c      = bg_gnt ? bg_colour : aim_colour;
  assign in_range  = (px_x < 9'(X_MAX)) & (px_y < 8'(Y_MAX));
  always_comb begin
    state_n    = state;
    last_aim_n = last_aim;
    case (state)
      IDLE:
        state_n = (bg_req & aim_req_e) ? (last_aim ? SERVE_BG : SERVE_AIM) :
                  bg_req ? SERVE_BG : aim_req_e ? SERVE_AIM : IDLE;
      SERVE_BG:
        if (!bg_req | (at_limit & aim_req_e)) begin
          state_n    = aim_req_e ? SERVE_AIM : IDLE;
          last_aim_n = 1'b0;
        end
      SERVE_AIM:
        if (!aim_req_e | (at_limit & bg_req)) begin
          state_n    = bg_req ? SERVE_BG : IDLE;
          last_aim_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
    burst_n = (state_n != state) ? '0 : !xfer ? burst : at_limit ? '0 : burst + BW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_aim   <= 1'b0;
      burst      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state    <= state_n;
      last_aim <= last_aim_n;
      burst    <= burst_n;
      vga_plot <= xfer & in_range;
      if (xfer & in_range) begin
        vga_x      <= px_x;
        vga_y      <= px_y;
        vga_colour <= px_c;
      end
      if (xfer & !in_range & (drop_cnt != 8'hff)) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: random stimulus, reference arbiter model feeding a scoreboard of expected vga outputs.
module tb_vga_plot_arbiter;
  localparam int BM = 4;
  logic clk = 0, reset = 1, aim_en = 1;
  logic bg_req = 1, aim_req = 1, bg_gnt, aim_gnt, vga_plot;
  logic [8:0] bg_x = 0, aim_x = 0, vga_x;
  logic [7:0] bg_y = 0, aim_y = 0, vga_y, drop_cnt;
  logic [2:0] bg_colour = 0, aim_colour = 0, vga_colour;
  int checks = 0, failures = 0;
  bit run_en = 1;
  typedef struct {bit plot; logic [8:0] x; logic [7:0] y; logic [2:0] c; int drop;} exp_t;
  exp_t q[$];
  int owner = 0, last = 1, run = 0, drop = 0;
  vga_plot_arbiter #(.BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .aim_en(aim_en),
    .bg_req(bg_req), .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour), .bg_gnt(bg_gnt),
    .aim_req(aim_req), .aim_x(aim_x), .aim_y(aim_y), .aim_colour(aim_colour), .aim_gnt(aim_gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  // Reference model: owner 0=none 1=BG 2=AIM; run counts transfers in the current burst.
  always @(negedge clk) if (run_en) begin
    bit ae, bx, ax;
    exp_t e;
    checks++;
    if (bg_gnt !== (owner == 1) || aim_gnt !== (owner == 2)) begin
      failures++;
      $display("FAIL gnt t=%0t bg_gnt=%b aim_gnt=%b expected owner=%0d", $time, bg_gnt, aim_gnt, owner);
    end
    e = '{0, 0, 0, 0, drop};
    if (reset) begin
      owner = 0; last = 1; run = 0; drop = 0; e.drop = 0;
    end else begin
      ae = aim_req & aim_en;
      bx = owner == 1 && bg_req;
      ax = owner == 2 && ae;
      if (bx || ax) begin
        e.x = bx ? bg_x : aim_x;
        e.y = bx ? bg_y : aim_y;
        e.c = bx ? bg_colour : aim_colour;
        if (int'(e.x) < 320 && int'(e.y) < 240) e.plot = 1;
        else begin
          drop = drop < 255 ? drop + 1 : 255;
          e.drop = drop;
        end
      end
      if (owner == 0) owner = (bg_req && ae) ? (last == 1 ? 2 : 1) : bg_req ? 1 : ae ? 2 : 0;
      else if (!(owner == 1 ? bg_req : ae)) begin
        last = owner; run = 0;
        owner = owner == 1 ? (ae ? 2 : 0) : (bg_req ? 1 : 0);
      end else if (++run == BM) begin
        run = 0;
        if (owner == 1 ? ae : bg_req) begin last = owner; owner = 3 - owner; end
      end
    end
    q.push_back(e);
  end
  // Monitor: each output cycle consumes the expectation produced one cycle earlier.
  always @(negedge clk) if (run_en) begin
    exp_t e;
    #1;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = q.pop_front();
      if (vga_plot !== e.plot || int'(drop_cnt) != e.drop ||
          (e.plot && (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c))) begin
        failures++;
        $display("FAIL pixel t=%0t got plot=%b (%0d,%0d,%0d) drop=%0d expected plot=%b (%0d,%0d,%0d) drop=%0d",
                 $time, vga_plot, vga_x, vga_y, vga_colour, drop_cnt, e.plot, e.x, e.y, e.c, e.drop);
      end
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic rand_px(input bit bad);
    bg_x = bad ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 319));
    bg_y = bad ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239));
    aim_x = 9'($urandom_range(0, 330));
    aim_y = 8'($urandom_range(0, 245));
    bg_colour = 3'($urandom); aim_colour = 3'($urandom);
  endtask
  initial begin
    q.push_back('{0, 0, 0, 0, 0});
    tick();
    checks++;
    if (vga_x !== 0 || vga_y !== 0 || vga_colour !== 0 || drop_cnt !== 0 || vga_plot !== 0) begin
      failures++;
      $display("FAIL reset_outputs x=%0d y=%0d c=%0d drop=%0d plot=%b required all 0", vga_x, vga_y, vga_colour, drop_cnt, vga_plot);
    end
    tick();
    reset = 0;
    for (int i = 0; i < 20; i++) begin rand_px(0); tick(); end
    aim_req = 0;
    for (int i = 0; i < 30; i++) begin bg_x = 9'(5 + i); bg_y = 7; bg_colour = 3; tick(); end
    aim_req = 1;
    for (int i = 0; i < 24; i++) begin rand_px(0); tick(); end
    bg_req = 0; aim_en = 0;
    for (int i = 0; i < 10; i++) begin rand_px(0); tick(); end
    aim_req = 0; aim_en = 1; bg_req = 1;
    bg_x = 320; bg_y = 10; bg_colour = 7; tick();
    tick();
    bg_x = 10; bg_y = 240; tick();
    for (int i = 0; i < 300; i++) begin rand_px(1); tick(); end
    bg_req = 0;
    tick(); tick();
    aim_req = 1;
    begin
      int n = 0;
      while (aim_gnt !== 1'b1 && n < 10) begin rand_px(0); tick(); n++; end
      checks++;
      if (n == 10) begin failures++; $display("FAIL aim_grant_timeout aim_gnt=%b required 1", aim_gnt); end
    end
    tick();
    reset = 1; tick(); reset = 0;
    bg_req = 1;
    for (int i = 0; i < 2000; i++) begin
      rand_px($urandom_range(0, 9) == 0);
      bg_req = $urandom_range(0, 3) != 0;
      aim_req = $urandom_range(0, 2) != 0;
      aim_en = $urandom_range(0, 15) != 0;
      reset = $urandom_range(0, 199) == 0;
      tick();
    end
    reset = 0; bg_req = 0; aim_req = 0;
    tick(); tick(); tick();
    run_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
